// File: rtl/dot_pipe_pkg.sv
// Shared constants and helpers for the dot_pipe multiply/adder-tree pipeline.
package dot_pipe_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_LANES = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Element offset of tree level lvl inside the flattened tree vector
   // (level 0 = products, level log2(lanes) = single final sum).
   function automatic int lvl_base(input int lanes, input int lvl);
      return 2 * lanes - 2 * (lanes >> lvl);
   endfunction

   localparam int DEF_STAGES = 1 + clog2(DEF_LANES);

endpackage

// File: rtl/dot_pipe_add_stage.sv
// One registered adder-tree level: N operands reduced to N/2 pairwise sums,
// with a valid bit, frozen while en is low.
module dot_pipe_add_stage #(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     en,
   input  logic                     operand_valid,
   input  logic [N*WIDTH-1:0]       operands,
   output logic                     sum_valid,
   output logic [(N/2)*WIDTH-1:0]   sums
);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sum_valid <= 1'b0;
         sums      <= '0;
      end else if (en) begin
         sum_valid <= operand_valid;
         // Bubbles keep the previous sums so the output data never churns.
         if (operand_valid) begin
            for (int i = 0; i < N / 2; i++) begin
               sums[i*WIDTH +: WIDTH] <= operands[(2*i)*WIDTH +: WIDTH]
                                       + operands[(2*i+1)*WIDTH +: WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/dot_pipe.sv
// Pipelined unsigned dot product: registered products, then a registered
// pairwise adder tree. Optional group accumulation with DOT_PIPE_ACCUM_EN.
module dot_pipe
   import dot_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [LANES*WIDTH-1:0]   A,
   input  logic [LANES*WIDTH-1:0]   B,
`ifdef DOT_PIPE_ACCUM_EN
   input  logic                     In_Last,
`endif
   output logic                     Out_Valid,
   input  logic                     Out_Ready,
   output logic [WIDTH-1:0]         C
);

   localparam int STAGES = 1 + clog2(LANES);
   localparam int LEVELS = STAGES - 1;
   localparam int TREE_W = (2 * LANES - 1) * WIDTH;

   logic                  advance;
   logic                  accept;
   logic [LANES*WIDTH-1:0] prod_reg;
   logic                  prod_valid_reg;
   logic [TREE_W-1:0]     tree;
   logic [LEVELS:0]       tree_valid;
   logic [WIDTH-1:0]      tree_out;

   // One global enable: everything moves unless a finished result is blocked.
   assign advance  = Out_Ready || !Out_Valid;
   assign In_Ready = advance;
   assign accept   = In_Valid && advance;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         prod_valid_reg <= 1'b0;
         prod_reg       <= '0;
      end else if (advance) begin
         prod_valid_reg <= In_Valid;
         if (In_Valid) begin
            for (int i = 0; i < LANES; i++) begin
               prod_reg[i*WIDTH +: WIDTH] <= A[i*WIDTH +: WIDTH] * B[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign tree[LANES*WIDTH-1:0] = prod_reg;
   assign tree_valid[0]         = prod_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LEVELS; gi++) begin : gen_level
         localparam int N      = LANES >> gi;
         localparam int IN_LO  = lvl_base(LANES, gi) * WIDTH;
         localparam int OUT_LO = lvl_base(LANES, gi + 1) * WIDTH;

         dot_pipe_add_stage #(
            .WIDTH (WIDTH),
            .N     (N)
         ) u_add (
            .Clk           (Clk),
            .Reset_n       (Reset_n),
            .en            (advance),
            .operand_valid (tree_valid[gi]),
            .operands      (tree[IN_LO +: N*WIDTH]),
            .sum_valid     (tree_valid[gi+1]),
            .sums          (tree[OUT_LO +: (N/2)*WIDTH])
         );
      end
   endgenerate

   assign tree_out = tree[TREE_W-1 -: WIDTH];

`ifdef DOT_PIPE_ACCUM_EN
   logic [LEVELS:0]  last_reg;
   logic [WIDTH-1:0] acc_reg;

   // The last flag rides alongside each stage's valid bit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_reg <= '0;
      end else if (advance) begin
         last_reg <= {last_reg[LEVELS-1:0], In_Last & In_Valid};
      end
   end

   // acc_reg holds the sum of the group's earlier vectors; the final vector
   // is added on the output path so the group result keeps the base latency.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_reg <= '0;
      end else if (advance && tree_valid[LEVELS]) begin
         acc_reg <= last_reg[LEVELS] ? '0 : acc_reg + tree_out;
      end
   end

   assign Out_Valid = tree_valid[LEVELS] && last_reg[LEVELS];
   assign C         = acc_reg + tree_out;
`else
   assign Out_Valid = tree_valid[LEVELS];
   assign C         = tree_out;
`endif

endmodule

// File: tb/tb_dot_pipe.sv
// Scoreboard bench for dot_pipe (default 32x4 instance plus an 8-bit wrap instance).
module tb_dot_pipe;

   localparam int W  = 32;
   localparam int L  = 4;
   localparam int W8 = 8;
`ifdef DOT_PIPE_ACCUM_EN
   localparam bit ACCUM = 1'b1;
`else
   localparam bit ACCUM = 1'b0;
`endif

   logic           Clk = 1'b0;
   logic           Reset_n;
   logic           In_Valid, In_Ready, Out_Valid, Out_Ready;
   logic [L*W-1:0] A, B;
   logic [W-1:0]   C;
   logic           v8, rdy8, ov8, or8;
   logic [L*W8-1:0] a8, b8;
   logic [W8-1:0]  c8;
`ifdef DOT_PIPE_ACCUM_EN
   logic           In_Last;
   logic           last8;
`endif

   always #5 Clk = ~Clk;

   dot_pipe #(.WIDTH(W), .LANES(L)) u_dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .A         (A),
      .B         (B),
`ifdef DOT_PIPE_ACCUM_EN
      .In_Last   (In_Last),
`endif
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .C         (C)
   );

   dot_pipe #(.WIDTH(W8), .LANES(L)) u_dut8 (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_Valid  (v8),
      .In_Ready  (rdy8),
      .A         (a8),
      .B         (b8),
`ifdef DOT_PIPE_ACCUM_EN
      .In_Last   (last8),
`endif
      .Out_Valid (ov8),
      .Out_Ready (or8),
      .C         (c8)
   );

   typedef struct {
      logic [W-1:0] val;
      int           acc_cyc;
      bit           lat;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   logic [W-1:0] grp_sum = '0;
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   int           n_out = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] dot(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < L; i++) s = s + W'(a[i*W +: W] * b[i*W +: W]);
      return s;
   endfunction

   // Scoreboard model: one result per vector, or one per group when accumulating.
   task automatic model_push(input logic [W-1:0] d, input bit last, input int c0, input bit lat);
      exp_t x;
      grp_sum = grp_sum + d;
      if (last || !ACCUM) begin
         x.val     = grp_sum;
         x.acc_cyc = c0;
         x.lat     = lat;
         exp_q.push_back(x);
         grp_sum = '0;
      end
   endtask

   always @(negedge Clk) begin
      if (Reset_n && Out_Valid && Out_Ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("result C=%0d expected=%0d cycle=%0d", C, e.val, cyc);
            chk("result", C, e.val);
            if (e.lat) chk("latency", cyc - e.acc_cyc, 3);
            n_out++;
         end
      end
   end

   task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                       input bit last, input bit lat, output int waited);
      bit rdy;
      int c0;
      In_Valid = 1'b1;
      A = a;
      B = b;
`ifdef DOT_PIPE_ACCUM_EN
      In_Last = last;
`endif
      waited = 0;
      rdy = 1'b0;
      c0 = 0;
      forever begin
         @(negedge Clk);
         rdy = In_Ready;
         c0  = cyc;
         @(posedge Clk);
         #1;
         if (rdy) break;
         waited++;
         if (waited > 100) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      if (rdy) model_push(dot(a, b), last, c0, lat);
      In_Valid = 1'b0;
      A = {4{$urandom()}};
      B = {4{$urandom()}};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 60) begin
         @(negedge Clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(posedge Clk);
      #1;
   endtask

   task automatic send8(input logic [L*W8-1:0] a, input logic [L*W8-1:0] b, input logic [W8-1:0] exp);
      int n;
      n = 0;
      v8 = 1'b1;
      a8 = a;
      b8 = b;
      @(posedge Clk);
      #1;
      v8 = 1'b0;
      a8 = $urandom();
      b8 = $urandom();
      while (!ov8 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      $display("wrap8 C=%0d expected=%0d", c8, exp);
      chk("wrap_valid", ov8, 1);
      chk("wrap_c", c8, exp);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n0;
      Reset_n   = 1'b0;
      In_Valid  = 1'b0;
      Out_Ready = 1'b1;
      A = '0;
      B = '0;
      v8 = 1'b0;
      or8 = 1'b1;
      a8 = '0;
      b8 = '0;
`ifdef DOT_PIPE_ACCUM_EN
      In_Last = 1'b1;
      last8   = 1'b1;
`endif
      #1;
      chk("rst_out_valid", Out_Valid, 0);
      chk("rst_c", C, 0);
      chk("rst_in_ready", In_Ready, 1);
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // single vector 1,2,3,4 . 5,6,7,8 = 70 with latency check
      send({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b1, 1'b1, w);
      drain();

      // 8-bit wrap cases
      send8({8'd0, 8'd0, 8'd16, 8'd16}, {8'd0, 8'd0, 8'd1, 8'd16}, 8'd16);
      send8({4{8'hFF}}, {4{8'hFF}}, 8'd4);
      send8({4{8'd100}}, {4{8'd3}}, 8'd176);

      // back-to-back stream of 10 vectors
      for (int k = 0; k < 10; k++) begin
         send({$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1, w);
         chk("stream_in_ready", w, 0);
      end
      drain();

      // backpressure with a full pipeline
      Out_Ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++)
               send({$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, w);
         end
         begin
            int n;
            n = 0;
            while (!Out_Valid && n < 50) begin
               @(negedge Clk);
               n++;
            end
            chk("bp_fill", Out_Valid, 1);
            repeat (5) begin
               @(negedge Clk);
               chk("bp_valid", Out_Valid, 1);
               chk("bp_c", C, (exp_q.size() > 0) ? exp_q[0].val : ~C);
               chk("bp_in_ready", In_Ready, 0);
            end
            @(posedge Clk);
            #1;
            Out_Ready = 1'b1;
         end
      join
      drain();

      // reset with two vectors in flight
      send({$urandom(), $urandom(), $urandom(), $urandom()}, {4{32'd3}}, 1'b1, 1'b0, w);
      send({$urandom(), $urandom(), $urandom(), $urandom()}, {4{32'd5}}, 1'b1, 1'b0, w);
      Reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", Out_Valid, 0);
      chk("midrst_c", C, 0);
      chk("midrst_in_ready", In_Ready, 1);
      exp_q.delete();
      grp_sum = '0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      repeat (6) @(posedge Clk);
      #1;
      n0 = n_out;
      send({32'd1, 32'd1, 32'd1, 32'd9}, {32'd2, 32'd2, 32'd2, 32'd2}, 1'b1, 1'b1, w);
      drain();
      chk("post_rst_results", n_out - n0, 1);

`ifdef DOT_PIPE_ACCUM_EN
      // groups: 70 + 10 + 20 = 100, then a fresh group of 4
      n0 = n_out;
      send({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, 1'b0, w);
      send({32'd1, 32'd1, 32'd1, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, w);
      send({32'd0, 32'd0, 32'd0, 32'd2}, {32'd0, 32'd0, 32'd0, 32'd10}, 1'b1, 1'b1, w);
      send({4{32'd1}}, {4{32'd1}}, 1'b1, 1'b0, w);
      drain();
      chk("acc_result_count", n_out - n0, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
